// File: rtl/bus_control.sv
// AHB-Lite single-master interconnect.
// Broadcasts the master's address/control/write data to every slave, decodes
// the address-phase address into a one-hot HSEL, and returns the data-phase
// slave's HRDATA/HREADYOUT/HRESP to the master and the shared HREADY line.
// The highest-index slave is the default region for every unmapped address.
module bus_control #(
  parameter int                           SLAVE_COUNT = 2,
  // Exclusive upper bounds, strictly increasing; entry i ends slave i.
  parameter logic [(SLAVE_COUNT-1)*32-1:0] ADDR_MAP   = {32'd2048}
) (
  input  logic                      clk,
  input  logic                      rst,
  // Master side
  input  logic [31:0]               m_addr,
  input  logic                      m_write,
  input  logic [2:0]                m_size,
  input  logic [2:0]                m_burst,
  input  logic [3:0]                m_prot,
  input  logic [1:0]                m_trans,
  input  logic                      m_mastlock,
  input  logic [31:0]               m_wdata,
  output logic [31:0]               m_rdata,
  output logic                      m_ready,
  output logic                      m_resp,
  // Slave side
  output logic [31:0]               s_addr,
  output logic                      s_write,
  output logic [2:0]                s_size,
  output logic [2:0]                s_burst,
  output logic [3:0]                s_prot,
  output logic [1:0]                s_trans,
  output logic                      s_mastlock,
  output logic [31:0]               s_wdata,
  output logic                      s_ready,
  output logic [SLAVE_COUNT-1:0]    s_sel,
  input  logic [SLAVE_COUNT*32-1:0] s_rdata,
  input  logic [SLAVE_COUNT-1:0]    s_readyout,
  input  logic [SLAVE_COUNT-1:0]    s_resp
);

  localparam int                IDX_W       = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
  localparam logic [IDX_W-1:0] DEFAULT_IDX = IDX_W'(SLAVE_COUNT - 1);

  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] dsel_q, dsel_d;
  logic [31:0]      rdata_arr [SLAVE_COUNT];

  // Map an address to its slave index. Scanning the bounds from the top down
  // leaves the lowest region whose bound exceeds the address; anything at or
  // above the last bound falls through to the default slave.
  function automatic logic [IDX_W-1:0] decode(input logic [31:0] addr);
    logic [IDX_W-1:0] idx;
    idx = DEFAULT_IDX;
    for (int i = SLAVE_COUNT - 2; i >= 0; i--) begin
      if (addr < ADDR_MAP[32*i +: 32]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Master address and control reach every slave with no added latency.
  assign s_addr     = m_addr;
  assign s_write    = m_write;
  assign s_size     = m_size;
  assign s_burst    = m_burst;
  assign s_prot     = m_prot;
  assign s_trans    = m_trans;
  assign s_mastlock = m_mastlock;
  assign s_wdata    = m_wdata;

  // Address decode depends on the address alone, not on HTRANS.
  assign dec_idx = decode(m_addr);

  // One-hot HSEL from the decoded index.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    s_sel          = '0;
    s_sel[dec_idx] = 1'b1;
  end

  // Unpack the flat read-data bus so the data-phase mux is a plain index.
  always_comb begin
    for (int i = 0; i < SLAVE_COUNT; i++) begin
      rdata_arr[i] = s_rdata[32*i +: 32];
    end
  end

  // Data-phase mux driven by the registered data-phase index.
  assign m_rdata = rdata_arr[dsel_q];
  assign m_ready = s_readyout[dsel_q];
  assign m_resp  = s_resp[dsel_q];
  assign s_ready = m_ready;

  // The address phase becomes the data phase only when the bus is ready;
  // during wait states (including the first cycle of an ERROR) it holds.
  assign dsel_d = m_ready ? dec_idx : dsel_q;

  // Data-phase index register; reset parks it on the default slave.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst) begin
      dsel_q <= DEFAULT_IDX;
    end else begin
      dsel_q <= dsel_d;
    end
  end

endmodule

// File: tb/tb_bus_control.sv
// Directed bench for bus_control with two slaves (slave 1 is the default region
// starting at 0x800). A table of per-cycle vectors covers decode, data-phase
// muxing, wait states and ERROR; hand-written sequences cover reset behaviour.
module tb_bus_control;

  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   m_addr;
  logic          m_write;
  logic [2:0]    m_size;
  logic [2:0]    m_burst;
  logic [3:0]    m_prot;
  logic [1:0]    m_trans;
  logic          m_mastlock;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic          m_ready;
  logic          m_resp;
  logic [31:0]   s_addr;
  logic          s_write;
  logic [2:0]    s_size;
  logic [2:0]    s_burst;
  logic [3:0]    s_prot;
  logic [1:0]    s_trans;
  logic          s_mastlock;
  logic [31:0]   s_wdata;
  logic          s_ready;
  logic [SC-1:0] s_sel;
  logic [SC*32-1:0] s_rdata;
  logic [SC-1:0] s_readyout;
  logic [SC-1:0] s_resp;

  int checks   = 0;
  int failures = 0;

  bus_control #(.SLAVE_COUNT(SC), .ADDR_MAP({32'd2048})) dut (
    .clk(clk), .rst(rst),
    .m_addr(m_addr), .m_write(m_write), .m_size(m_size), .m_burst(m_burst),
    .m_prot(m_prot), .m_trans(m_trans), .m_mastlock(m_mastlock), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_resp(m_resp),
    .s_addr(s_addr), .s_write(s_write), .s_size(s_size), .s_burst(s_burst),
    .s_prot(s_prot), .s_trans(s_trans), .s_mastlock(s_mastlock), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_sel(s_sel),
    .s_rdata(s_rdata), .s_readyout(s_readyout), .s_resp(s_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_slaves(input logic [31:0] rd0, input logic rdy0, input logic rsp0,
                              input logic [31:0] rd1, input logic rdy1, input logic rsp1);
    s_rdata    = {rd1, rd0};
    s_readyout = {rdy1, rdy0};
    s_resp     = {rsp1, rsp0};
  endtask

  task automatic check_data(input string tag, input logic [31:0] e_rdata,
                            input logic e_ready, input logic e_resp);
    check({tag, " m_rdata"}, m_rdata, e_rdata);
    check({tag, " m_ready"}, {31'd0, m_ready}, {31'd0, e_ready});
    check({tag, " m_resp"},  {31'd0, m_resp},  {31'd0, e_resp});
    check({tag, " s_ready"}, {31'd0, s_ready}, {31'd0, e_ready});
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd0;
    logic        rdy0;
    logic        rsp0;
    logic [31:0] rd1;
    logic        rdy1;
    logic        rsp1;
    logic [1:0]  sel;
    logic [31:0] e_rdata;
    logic        e_ready;
    logic        e_resp;
  } vec_t;

  localparam logic [31:0] J0 = 32'h5A5A_5A5A;  // slave 0 noise while not in data phase
  localparam logic [31:0] J1 = 32'hA5A5_A5A5;  // slave 1 noise while not in data phase

  vec_t vecs [12];

  initial begin
    // Comments give the data-phase slave seen in that cycle.
    vecs[0]  = '{32'h0000_0100, J0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 2'b01, 32'h0, 1'b1, 1'b0};            // ds=1
    vecs[1]  = '{32'h0000_07FF, 32'hDEAD_BEEF, 1'b1, 1'b0, J1, 1'b1, 1'b1, 2'b01, 32'hDEAD_BEEF, 1'b1, 1'b0}; // ds=0
    vecs[2]  = '{32'h0000_0800, 32'h1111_1111, 1'b1, 1'b0, J1, 1'b1, 1'b1, 2'b10, 32'h1111_1111, 1'b1, 1'b0}; // ds=0
    vecs[3]  = '{32'h0000_0000, J0, 1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 2'b01, 32'h2222_2222, 1'b1, 1'b0}; // ds=1
    vecs[4]  = '{32'h0000_0900, 32'h3333_3333, 1'b0, 1'b0, J1, 1'b1, 1'b1, 2'b10, 32'h3333_3333, 1'b0, 1'b0}; // ds=0 stall
    vecs[5]  = '{32'h0000_0900, 32'h3333_3333, 1'b0, 1'b0, J1, 1'b1, 1'b1, 2'b10, 32'h3333_3333, 1'b0, 1'b0}; // ds=0 stall
    vecs[6]  = '{32'h0000_0900, 32'h4444_4444, 1'b1, 1'b0, J1, 1'b1, 1'b1, 2'b10, 32'h4444_4444, 1'b1, 1'b0}; // ds=0 done
    vecs[7]  = '{32'hFFFF_FFFF, J0, 1'b0, 1'b1, 32'h5555_5555, 1'b1, 1'b0, 2'b10, 32'h5555_5555, 1'b1, 1'b0}; // ds=1
    vecs[8]  = '{32'h0000_0000, J0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 2'b01, 32'h0, 1'b1, 1'b0};            // ds=1
    vecs[9]  = '{32'h0000_0000, 32'h0, 1'b0, 1'b1, J1, 1'b1, 1'b0, 2'b01, 32'h0, 1'b0, 1'b1};            // ds=0 ERROR 1st
    vecs[10] = '{32'h0000_0800, 32'h0, 1'b1, 1'b1, J1, 1'b1, 1'b0, 2'b10, 32'h0, 1'b1, 1'b1};            // ds=0 ERROR 2nd
    vecs[11] = '{32'h0000_0000, J0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 2'b01, 32'h0, 1'b1, 1'b0};            // ds=1

    // ---- Reset state ----
    rst        = 1'b0;
    m_addr     = 32'h0;
    m_write    = 1'b0;
    m_size     = 3'd2;
    m_burst    = 3'd0;
    m_prot     = 4'h3;
    m_trans    = 2'd0;
    m_mastlock = 1'b0;
    m_wdata    = 32'h0;
    drive_slaves(J0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);

    @(negedge clk); #1;
    check_data("reset", 32'h0, 1'b1, 1'b0);
    check("reset s_sel@0", {30'd0, s_sel}, 32'h1);
    check("reset s_addr", s_addr, 32'h0);
    m_addr = 32'h0000_0800;
    #1;
    check("reset s_sel@800", {30'd0, s_sel}, 32'h2);
    check("reset s_addr@800", s_addr, 32'h0000_0800);

    // Release with the default region addressed so the data phase stays there.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_data("post-release", 32'h0, 1'b1, 1'b0);

    // ---- Table-driven vectors ----
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      m_addr     = vecs[i].addr;
      m_write    = i[0];
      m_size     = 3'(i);
      m_burst    = 3'(i + 3);
      m_prot     = 4'(i * 5);
      m_trans    = 2'(i + 2);
      m_mastlock = i[1];
      m_wdata    = ~vecs[i].addr ^ 32'(i);
      drive_slaves(vecs[i].rd0, vecs[i].rdy0, vecs[i].rsp0,
                   vecs[i].rd1, vecs[i].rdy1, vecs[i].rsp1);
      #1;
      check($sformatf("v%0d s_sel", i), {30'd0, s_sel}, {30'd0, vecs[i].sel});
      check_data($sformatf("v%0d", i), vecs[i].e_rdata, vecs[i].e_ready, vecs[i].e_resp);
      check($sformatf("v%0d s_addr", i), s_addr, vecs[i].addr);
      check($sformatf("v%0d s_wdata", i), s_wdata, ~vecs[i].addr ^ 32'(i));
      check($sformatf("v%0d s_ctrl", i),
            {18'd0, s_write, s_size, s_burst, s_prot, s_trans, s_mastlock},
            {18'd0, i[0], 3'(i), 3'(i + 3), 4'(i * 5), 2'(i + 2), i[1]});
    end

    // ---- Reset asserted during a slave 0 stall ----
    @(negedge clk);
    m_addr = 32'h0000_0100;
    drive_slaves(32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check_data("h1", 32'h1234_5678, 1'b1, 1'b0);  // data phase from v11's address 0x0

    @(negedge clk);
    m_addr = 32'h0000_0800;
    drive_slaves(32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check_data("h2 stall", 32'h1234_5678, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check_data("h2 async rst", 32'h0, 1'b1, 1'b0);
    check("h2 s_sel in rst", {30'd0, s_sel}, 32'h2);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check_data("h3 released", 32'h0, 1'b1, 1'b0);

    @(negedge clk);
    m_addr = 32'h0000_0000;
    drive_slaves(32'h1234_5678, 1'b0, 1'b0, 32'h6666_6666, 1'b1, 1'b0);
    #1;
    check_data("h4 default dp", 32'h6666_6666, 1'b1, 1'b0);
    check("h4 s_sel", {30'd0, s_sel}, 32'h1);

    @(negedge clk);
    drive_slaves(32'h7777_7777, 1'b1, 1'b0, J1, 1'b1, 1'b1);
    #1;
    check_data("h5 slave0 dp", 32'h7777_7777, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_control.md
Name: bus_control

Overview:
- AHB-Lite single-master interconnect between the CPU control unit (master) and SLAVE_COUNT slaves.
- Decodes the address-phase address into a one-hot slave select.
- Broadcasts master address/control/write data to all slaves.
- Multiplexes the data-phase slave's read data, ready and response back to the master and to the shared HREADY line.
- The highest-index slave is the default (no-slave) region covering all unmapped addresses.

Parameters:
- SLAVE_COUNT, 2, number of slave ports (>=2); index SLAVE_COUNT-1 is the default region.
- ADDR_MAP, {32'd2048}, packed (SLAVE_COUNT-1)x32 upper bounds (exclusive), strictly increasing; entry i is the end of slave i.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset.
- m_addr, input, 32, master HADDR.
- m_write, input, 1, master HWRITE.
- m_size, input, 3, master HSIZE.
- m_burst, input, 3, master HBURST.
- m_prot, input, 4, master HPROT.
- m_trans, input, 2, master HTRANS (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- m_mastlock, input, 1, master HMASTLOCK.
- m_wdata, input, 32, master HWDATA.
- m_rdata, output, 32, HRDATA to master.
- m_ready, output, 1, HREADY to master.
- m_resp, output, 1, HRESP to master (0 OKAY, 1 ERROR).
- s_addr/s_write/s_size/s_burst/s_prot/s_trans/s_mastlock/s_wdata, output, 32/1/3/3/4/2/1/32, broadcast copies of master signals.
- s_ready, output, 1, shared HREADY to all slaves (equals m_ready).
- s_sel, output, SLAVE_COUNT, one-hot HSELx.
- s_rdata, input, SLAVE_COUNT*32, per-slave HRDATA (slave i at bits [32i+31:32i]).
- s_readyout, input, SLAVE_COUNT, per-slave HREADYOUT.
- s_resp, input, SLAVE_COUNT, per-slave HRESP.

Behaviour:
- Broadcast outputs are combinational passthroughs of the master inputs; no added latency.
- Address decode is combinational and depends on m_addr only, independent of m_trans.
  - Slave 0 is selected for m_addr < ADDR_MAP[0].
  - Slave i (0<i<SLAVE_COUNT-1) is selected for ADDR_MAP[i-1] <= m_addr < ADDR_MAP[i].
  - The default slave is selected for m_addr >= ADDR_MAP[SLAVE_COUNT-2].
  - Comparisons are unsigned 32-bit. s_sel is always exactly one-hot.
- Data-phase index register dsel, log2(SLAVE_COUNT) bits:
  - On posedge clk, if m_ready=1, dsel <= index of the current decoded slave.
  - If m_ready=0, dsel holds.
  - Async reset (rst=0) sets dsel = SLAVE_COUNT-1.
- Data-phase mux, combinational from dsel:
  - m_rdata = s_rdata[dsel], m_ready = s_readyout[dsel], m_resp = s_resp[dsel], s_ready = m_ready.
- Reset values:
  - dsel = default slave, so m_ready/m_resp/m_rdata follow the default slave's outputs. The default slave idles at ready=1, resp=0, rdata=0.
  - Broadcast outputs mirror the inputs during reset.
  - s_sel reflects decode of m_addr during reset.
- Wait states: while the data-phase slave drives readyout=0, dsel is frozen. A new address presented by the master during this time changes s_sel immediately but does not change the data-phase mux.
- Two-cycle ERROR: resp=1 with ready=0, then resp=1 with ready=1. Both cycles are forwarded unchanged; dsel updates only on the second cycle.
- Boundaries:
  - m_addr = ADDR_MAP[i]-1 selects slave i; m_addr = ADDR_MAP[i] selects slave i+1.
  - m_addr = 0xFFFFFFFF selects the default slave.
- Reset asserted mid-transfer forces dsel to the default slave immediately (asynchronous). No state other than dsel exists.

Test Plan:
- Reset, default slave readyout=1/resp=0/rdata=0 -> m_ready=1, m_resp=0, m_rdata=0; with m_addr=0x0, s_sel=2'b01.
- NONSEQ read at 0x100, slave0 rdata=0xDEADBEEF readyout=1 in the next cycle -> s_sel=01 in the address cycle; m_rdata=0xDEADBEEF in the data cycle.
- Address 0x7FF then 0x800 back-to-back -> s_sel 01 then 10; data phase of the second transfer is muxed from slave1.
- Slave0 readyout=0 for 2 cycles while the master presents 0x900 -> m_ready=0 for 2 cycles, s_sel=10, m_rdata still slave0's, dsel switches to slave1 after the stall.
- Slave0 ERROR (resp=1,ready=0 then resp=1,ready=1) -> m_resp=1 both cycles, m_ready 0 then 1.
- Assert rst during a slave0 stall -> m_ready immediately follows the default slave (1); after release, the next transfer decodes normally.
